// File: rtl/pwm_avalon_multi_if.sv
// Avalon-MM slave bus bundle for the multi-channel PWM block.
interface pwm_avalon_multi_if;
  logic        read;
  logic        write;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output read, write, address, writedata, input readdata);
  modport slave  (input read, write, address, writedata, output readdata);
endinterface

// File: rtl/pwm_avalon_multi.sv
// Multi-channel PWM with shared prescaler/duty counter and double-buffered duty registers.
// Optional interrupt (STATUS at 0xF, irq port) enabled by defining PWM_AVALON_IRQ_EN.
module pwm_avalon_multi #(
  parameter int CHANNELS = 4,
  parameter int R        = 10
) (
  input  logic                clock,
  input  logic                resetn,
  pwm_avalon_multi_if.slave   bus,
  output logic [CHANNELS-1:0] pwm_export
`ifdef PWM_AVALON_IRQ_EN
  ,
  output logic                irq
`endif
);
  localparam logic [R-1:0] D_MAX = '1;

  logic [CHANNELS-1:0] ctrl_en;
  logic                ctrl_irq;
  logic [31:0]         dvsr;
  logic [R:0]          duty   [CHANNELS];
  logic [R:0]          active [CHANNELS];
  logic [31:0]         q;
  logic [R-1:0]        d;
  logic                tick;
  logic                boundary;
  logic                dvsr_wr;
  logic [31:0]         rd_mux;

  assign tick     = (q == dvsr);
  assign boundary = tick && (d == D_MAX);
  assign dvsr_wr  = bus.write && (bus.address == 4'h1);

`ifdef PWM_AVALON_IRQ_EN
  logic status;

  assign irq = status && ctrl_irq;

  // Set at the period boundary takes priority over a software clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      status <= 1'b0;
    end else if (boundary) begin
      status <= 1'b1;
    end else if (bus.write && (bus.address == 4'hF) && bus.writedata[0]) begin
      status <= 1'b0;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    if (bus.address == 4'h0) begin
      rd_mux[CHANNELS-1:0] = ctrl_en;
      rd_mux[31]           = ctrl_irq;
    end else if (bus.address == 4'h1) begin
      rd_mux = dvsr;
`ifdef PWM_AVALON_IRQ_EN
    end else if (bus.address == 4'hF) begin
      rd_mux[0] = status;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.address == 4'(i + 2)) rd_mux = 32'(duty[i]);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ctrl_en      <= '0;
      ctrl_irq     <= 1'b0;
      dvsr         <= '0;
      bus.readdata <= '0;
      for (int i = 0; i < CHANNELS; i++) duty[i] <= '0;
    end else begin
      if (bus.read) bus.readdata <= rd_mux;
      if (bus.write && (bus.address == 4'h0)) begin
        ctrl_en  <= bus.writedata[CHANNELS-1:0];
        ctrl_irq <= bus.writedata[31];
      end
      if (dvsr_wr) dvsr <= bus.writedata;
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.write && (bus.address == 4'(i + 2))) duty[i] <= bus.writedata[R:0];
      end
    end
  end

  // Prescaler and shared duty counter; a DVSR write restarts both from zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
      d <= '0;
    end else if (dvsr_wr) begin
      q <= '0;
      d <= '0;
    end else if (tick) begin
      q <= '0;
      d <= d + 1'b1;
    end else begin
      q <= q + 32'd1;
    end
  end

  // Active compare values reload from the shadow only at the boundary (or freely while disabled),
  // so a shadow write never changes the waveform mid-period.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pwm_export <= '0;
      for (int i = 0; i < CHANNELS; i++) active[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary || !ctrl_en[i]) active[i] <= duty[i];
        pwm_export[i] <= ctrl_en[i] && ({1'b0, d} < active[i]);
      end
    end
  end
endmodule

// File: doc/pwm_avalon_multi.md
PWM_AVALON_MULTI -- requirements
Module: pwm_avalon_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of PWM outputs (range 1..13).
REQ-002 SHALL have parameter R, default 10, duty-counter resolution in bits (range 2..16).
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port read  input  1  Avalon-MM read strobe.
REQ-006 SHALL have port write  input  1  Avalon-MM write strobe.
REQ-007 SHALL have port address  input  4  word address.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  registered read data.
REQ-010 SHALL have port pwm_export  output  CHANNELS  PWM waveforms, bit i = channel i.

Function
REQ-011 SHALL use this register map: 0x0 CTRL, with bits[CHANNELS-1:0] as per-channel enable and bit31 as IRQ enable; 0x1 DVSR, 32-bit prescaler; 0x2+i DUTY[i] shadow, R+1 bits, for i < CHANNELS.
REQ-012 SHALL store writedata into the addressed register at the clock edge where write=1; writes to unmapped addresses and to unused bits SHALL be ignored.
REQ-013 SHALL update readdata one cycle after read=1 with the addressed register value; unused bits and unmapped addresses SHALL read 0.
REQ-014 SHALL hold readdata when read=0; read and write in the same cycle to the same address SHALL return the old value.
REQ-015 SHALL count prescaler q from 0 to DVSR and assert tick when q==DVSR, then wrap q to 0; DVSR=0 SHALL give tick every cycle.
REQ-016 SHALL advance the shared R-bit duty counter d by 1 on each tick, wrapping from 2^R-1 to 0.
REQ-017 SHALL treat tick with d==2^R-1 as the period boundary.
REQ-018 SHALL register pwm_export[i] = CTRL[i] && (d < active[i]); active[i] >= 2^R SHALL give constant high and active[i]=0 SHALL give constant low.
REQ-019 SHALL load active[i] from DUTY[i] at every period boundary, giving glitch-free updates.
REQ-020 SHALL make active[i] track DUTY[i] every cycle while CTRL[i]=0.
REQ-021 SHALL load the pre-write shadow value when a DUTY write coincides with a boundary; the new value SHALL take effect at the following boundary.
REQ-022 SHALL restart q and d from 0 on the cycle after a DVSR write.

Reset
REQ-023 SHALL asynchronously clear CTRL, DVSR, DUTY[*], active[*], q, d, readdata and pwm_export to 0 when resetn is low.
REQ-024 SHALL restart from the all-zero state on the first edge after release of a mid-period reset; no pending update SHALL survive reset.

Configuration
REQ-025 SHALL support macro PWM_AVALON_IRQ_EN.
REQ-026 SHALL, when PWM_AVALON_IRQ_EN is defined, add output port irq (1 bit) and a STATUS register at 0xF whose bit0 sets at each period boundary.
REQ-027 SHALL, with PWM_AVALON_IRQ_EN defined, clear STATUS bit0 on a write of 1 to bit0; set wins over a simultaneous clear.
REQ-028 SHALL, with PWM_AVALON_IRQ_EN defined, drive irq = STATUS[0] && CTRL[31] and reset STATUS and irq to 0.
REQ-029 SHALL, when PWM_AVALON_IRQ_EN is undefined, omit the irq port and STATUS logic; 0xF SHALL read 0 and CTRL[31] SHALL be storage only.

Verification
REQ-030 SHALL cover: R=10, DVSR=0, DUTY[0]=256, CTRL=1 -> pwm_export[0] high 256 and low 768 cycles per 1024-cycle period.
REQ-031 SHALL cover: DVSR=3, DUTY[1]=1024, CTRL=2 -> pwm_export[1] constant high; DUTY[1]=0 -> low from the next boundary.
REQ-032 SHALL cover: DUTY[0]=100 rewritten to 900 mid-period -> current period keeps a 100-tick high, the next period has a 900-tick high, with no glitch.
REQ-033 SHALL cover: DUTY write on the exact boundary cycle -> old value is used for one more period.
REQ-034 SHALL cover: read 0x2 after writing 0x7FF with R=10 -> readdata=0x000007FF one cycle later; read 0xE -> 0.
REQ-035 SHALL cover, with PWM_AVALON_IRQ_EN: CTRL=0x80000001 -> irq rises at the boundary; write STATUS=1 -> irq low next cycle; resetn low mid-period -> all outputs 0 immediately.
